// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator sequencer and its digit accumulator.
package calc_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int MAX_MAG_DEF = 32767;

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_NEG  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;

    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        EXEC,
        RESULT,
        ERROR
    } seq_state_t;

    typedef enum logic [1:0] {
        K_NONE,
        K_DIGIT,
        K_OP,
        K_EQ
    } key_class_t;

    // Equal outranks any operator code; a key with neither is a digit ('#' arrives as 0).
    function automatic key_class_t classify_key(input logic take, input logic eq,
                                                input logic [2:0] op);
        if (!take) return K_NONE;
        if (eq) return K_EQ;
        if (op != OP_NONE) return K_OP;
        return K_DIGIT;
    endfunction

    function automatic logic is_binop(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/dec_accum.sv
// Sign-magnitude decimal append: y = sign(x) * (|x|*10 + digit), or x unchanged if the
// new magnitude would exceed MAX_MAG.
module dec_accum
    import calc_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MAX_MAG = MAX_MAG_DEF
) (
    input  logic signed [DATA_W-1:0] x,
    input  logic        [3:0]        digit,
    output logic signed [DATA_W-1:0] y
);

    localparam int CAND_W = 20;

    logic signed [DATA_W-1:0] neg_x;
    logic signed [DATA_W-1:0] cand_s;
    logic        [DATA_W-1:0] mag;
    logic        [CAND_W-1:0] cand;
    logic                     fits;

    always_comb begin
        neg_x  = -x;
        mag    = x[DATA_W-1] ? neg_x : x;
        // 20 bits holds the worst case 32768*10+9 without wrapping.
        cand   = CAND_W'(mag) * CAND_W'(10) + CAND_W'(digit);
        fits   = (cand <= CAND_W'(MAX_MAG));
        cand_s = $signed(cand[DATA_W-1:0]);
        y      = x;
        if (fits) begin
            y = x[DATA_W-1] ? -cand_s : cand_s;
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator controller: consumes keypad events, builds signed operands A/B,
// drives the ALU start/done handshake and holds display/error/busy status.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int MAX_MAG     = MAX_MAG_DEF,
    parameter int ALU_TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     RST,
    input  logic                     read_input,
    output logic                     key_read,
    input  logic        [3:0]        keypad_input,
    input  logic        [2:0]        operator_input,
    input  logic                     equal_input,
    output logic                     alu_start,
    output logic        [2:0]        alu_op,
    output logic signed [DATA_W-1:0] alu_a,
    output logic signed [DATA_W-1:0] alu_b,
    input  logic                     alu_done,
    input  logic signed [DATA_W-1:0] alu_result,
    input  logic                     alu_ovf,
    output logic signed [DATA_W-1:0] display_value,
    output logic                     err,
    output logic                     busy
);

    localparam int CNT_W = $clog2(ALU_TIMEOUT + 1);

    seq_state_t               state_q, state_n;
    logic signed [DATA_W-1:0] a_q, a_n;
    logic signed [DATA_W-1:0] b_q, b_n;
    logic        [2:0]        op_q, op_n;
    logic                     b_entered_q, b_entered_n;
    logic                     ack_done_q;
    logic        [CNT_W-1:0]  tmo_q, tmo_n;
    logic signed [DATA_W-1:0] disp_q, disp_n;

    logic                     take;
    key_class_t               kc;
    logic signed [DATA_W-1:0] acc_x, acc_y;
    logic signed [DATA_W-1:0] digit_s;

    // A key is taken once per press; EXEC leaves it pending until the state exits.
    assign take     = read_input && !ack_done_q && (state_q != EXEC) && !RST;
    assign key_read = take;
    assign kc       = classify_key(take, equal_input, operator_input);
    assign acc_x    = (state_q == ENTER_B) ? b_q : a_q;
    assign digit_s  = $signed({{(DATA_W-4){1'b0}}, keypad_input});

    dec_accum #(
        .DATA_W (DATA_W),
        .MAX_MAG(MAX_MAG)
    ) u_dec_accum (
        .x    (acc_x),
        .digit(keypad_input),
        .y    (acc_y)
    );

    always_comb begin
        state_n     = state_q;
        a_n         = a_q;
        b_n         = b_q;
        op_n        = op_q;
        b_entered_n = b_entered_q;
        tmo_n       = tmo_q;
        disp_n      = disp_q;

        case (state_q)
            ENTER_A: begin
                if (kc == K_DIGIT) begin
                    a_n = acc_y;
                end else if (kc == K_OP) begin
                    if (operator_input == OP_NEG) begin
                        a_n = -a_q;
                    end else if (is_binop(operator_input)) begin
                        op_n        = operator_input;
                        b_n         = '0;
                        b_entered_n = 1'b0;
                        state_n     = ENTER_B;
                    end
                end
            end
            ENTER_B: begin
                if (kc == K_DIGIT) begin
                    b_n         = acc_y;
                    b_entered_n = 1'b1;
                end else if (kc == K_OP) begin
                    if (operator_input == OP_NEG) begin
                        b_n = -b_q;
                    end else if (is_binop(operator_input) && !b_entered_q) begin
                        op_n = operator_input;
                    end
                end else if (kc == K_EQ && b_entered_q) begin
                    tmo_n   = '0;
                    state_n = EXEC;
                end
            end
            EXEC: begin
                if (alu_done) begin
                    if (alu_ovf) begin
                        state_n = ERROR;
                    end else begin
                        a_n     = alu_result;
                        state_n = RESULT;
                    end
                end else if (tmo_q == CNT_W'(ALU_TIMEOUT - 1)) begin
                    state_n = ERROR;
                end else begin
                    tmo_n = tmo_q + CNT_W'(1);
                end
            end
            RESULT: begin
                if (kc == K_DIGIT) begin
                    a_n     = digit_s;
                    state_n = ENTER_A;
                end else if (kc == K_OP) begin
                    if (operator_input == OP_NEG) begin
                        a_n = -a_q;
                    end else if (is_binop(operator_input)) begin
                        op_n        = operator_input;
                        b_n         = '0;
                        b_entered_n = 1'b0;
                        state_n     = ENTER_B;
                    end
                end
            end
            ERROR: begin
                if (kc != K_NONE) begin
                    a_n     = '0;
                    state_n = ENTER_A;
                end
            end
            default: state_n = ENTER_A;
        endcase

        // Display follows the next-state values so it lands one cycle after the key.
        case (state_n)
            ENTER_A: disp_n = a_n;
            ENTER_B: disp_n = b_entered_n ? b_n : a_n;
            RESULT:  disp_n = a_n;
            ERROR:   disp_n = '0;
            default: disp_n = disp_q;
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q     <= ENTER_A;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= OP_ADD;
            b_entered_q <= 1'b0;
            ack_done_q  <= 1'b0;
            tmo_q       <= '0;
            disp_q      <= '0;
            err         <= 1'b0;
            busy        <= 1'b0;
            alu_start   <= 1'b0;
            alu_op      <= OP_NONE;
            alu_a       <= '0;
            alu_b       <= '0;
        end else begin
            state_q     <= state_n;
            a_q         <= a_n;
            b_q         <= b_n;
            op_q        <= op_n;
            b_entered_q <= b_entered_n;
            ack_done_q  <= read_input && (ack_done_q || take);
            tmo_q       <= tmo_n;
            disp_q      <= disp_n;
            err         <= (state_n == ERROR);
            busy        <= (state_n == EXEC);
            alu_start   <= (state_n == EXEC) && (state_q != EXEC);
            // Operands are latched at EXEC entry and held until the next request.
            if ((state_n == EXEC) && (state_q != EXEC)) begin
                alu_op <= op_n;
                alu_a  <= a_n;
                alu_b  <= b_n;
            end
        end
    end

    assign display_value = disp_q;

endmodule
